// File: rtl/irq_arbiter.sv
// ============================================================================
// irq_arbiter : N maskable + 1 NMI interrupt arbiter with registered grant
// Revision    : 1.0
// ============================================================================
`default_nettype none

module irq_arbiter #(
    parameter int                 N_IRQ     = 8,
    parameter int                 ID_W      = (N_IRQ > 1) ? $clog2(N_IRQ) : 1,
    parameter logic [N_IRQ-1:0]   TRIG_EDGE = {N_IRQ{1'b1}}
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [N_IRQ-1:0] irq_i,
    input  logic             nmi_i,
    input  logic             intd_i,
    input  logic             mask_we_i,
    input  logic [N_IRQ-1:0] mask_wdata_i,
    output logic [N_IRQ-1:0] mask_o,
    output logic [N_IRQ-1:0] pending_o,
    input  logic             query_i,
    input  logic             eoi_i,
    output logic             take_o,
    output logic             take_nmi_o,
    output logic             ina_o,
    output logic [ID_W-1:0]  take_id_o,
    output logic             busy_o
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] INT_SVC = 2'd1;
    localparam logic [1:0] NMI_SVC = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             nested_q, nested_d;
    logic [N_IRQ-1:0] irq_prev_q;
    logic             nmi_prev_q;
    logic [N_IRQ-1:0] pend_q, pend_d;
    logic             nmi_pend_q, nmi_pend_d;
    logic [N_IRQ-1:0] mask_q;
    logic             take_q, take_d;
    logic             take_nmi_q, take_nmi_d;
    logic             ina_q, ina_d;
    logic [ID_W-1:0]  take_id_q, take_id_d;

    logic [1:0]       st_eoi;
    logic             nest_eoi;
    logic [N_IRQ-1:0] req;
    logic             sel_found;
    logic [ID_W-1:0]  sel_id;
    logic             grant_int;
    logic             grant_nmi;
    logic [N_IRQ-1:0] clr;

    assign req = pend_q & mask_q;

    // Descending scan so the lowest set index is the last one written.
    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                sel_found = 1'b1;
                sel_id    = ID_W'(i);
            end
        end
    end

    // eoi is resolved first; the query then arbitrates against that state.
    always_comb begin
        st_eoi   = state_q;
        nest_eoi = nested_q;
        if (eoi_i) begin
            case (state_q)
                NMI_SVC: begin
                    st_eoi   = nested_q ? INT_SVC : IDLE;
                    nest_eoi = 1'b0;
                end
                INT_SVC: st_eoi = IDLE;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d    = st_eoi;
        nested_d   = nest_eoi;
        take_d     = 1'b0;
        take_nmi_d = take_nmi_q;
        ina_d      = ina_q;
        take_id_d  = take_id_q;
        grant_int  = 1'b0;
        grant_nmi  = 1'b0;
        if (query_i && nmi_pend_q && (st_eoi != NMI_SVC)) begin
            grant_nmi  = 1'b1;
            take_d     = 1'b1;
            take_nmi_d = 1'b1;
            ina_d      = 1'b0;
            take_id_d  = '0;
            nested_d   = (st_eoi == INT_SVC);
            state_d    = NMI_SVC;
        end else if (query_i && (st_eoi == IDLE) && !intd_i && sel_found) begin
            grant_int  = 1'b1;
            take_d     = 1'b1;
            take_nmi_d = 1'b0;
            ina_d      = 1'b1;
            take_id_d  = sel_id;
            state_d    = INT_SVC;
        end
    end

    // Set beats a same-cycle clear on edge channels; level channels follow the line.
    always_comb begin
        clr        = grant_int ? (N_IRQ'(1) << sel_id) : '0;
        pend_d     = (TRIG_EDGE & ((irq_i & ~irq_prev_q) | (pend_q & ~clr)))
                   | (~TRIG_EDGE & irq_i);
        nmi_pend_d = (nmi_i & ~nmi_prev_q) | (nmi_pend_q & ~grant_nmi);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            nested_q   <= 1'b0;
            irq_prev_q <= '0;
            nmi_prev_q <= 1'b0;
            pend_q     <= '0;
            nmi_pend_q <= 1'b0;
            mask_q     <= '0;
            take_q     <= 1'b0;
            take_nmi_q <= 1'b0;
            ina_q      <= 1'b0;
            take_id_q  <= '0;
        end else begin
            state_q    <= state_d;
            nested_q   <= nested_d;
            irq_prev_q <= irq_i;
            nmi_prev_q <= nmi_i;
            pend_q     <= pend_d;
            nmi_pend_q <= nmi_pend_d;
            if (mask_we_i) begin
                mask_q <= mask_wdata_i;
            end
            take_q     <= take_d;
            take_nmi_q <= take_nmi_d;
            ina_q      <= ina_d;
            take_id_q  <= take_id_d;
        end
    end

    assign mask_o     = mask_q;
    assign pending_o  = pend_q;
    assign take_o     = take_q;
    assign take_nmi_o = take_nmi_q;
    assign ina_o      = ina_q;
    assign take_id_o  = take_id_q;
    assign busy_o     = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_irq_arbiter.sv
// ============================================================================
// tb_irq_arbiter : directed self-checking bench for irq_arbiter
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_irq_arbiter;

    localparam int         N  = 8;
    localparam int         IW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  irq;
    logic          nmi;
    logic          intd;
    logic          mask_we;
    logic [N-1:0]  mask_wdata;
    logic [N-1:0]  mask;
    logic [N-1:0]  pending;
    logic          query;
    logic          eoi;
    logic          take;
    logic          take_nmi;
    logic          ina;
    logic [IW-1:0] take_id;
    logic          busy;

    int checks = 0;
    int errors = 0;

    irq_arbiter #(.N_IRQ(N), .ID_W(IW), .TRIG_EDGE(8'hFE)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .irq_i        (irq),
        .nmi_i        (nmi),
        .intd_i       (intd),
        .mask_we_i    (mask_we),
        .mask_wdata_i (mask_wdata),
        .mask_o       (mask),
        .pending_o    (pending),
        .query_i      (query),
        .eoi_i        (eoi),
        .take_o       (take),
        .take_nmi_o   (take_nmi),
        .ina_o        (ina),
        .take_id_o    (take_id),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_query();
        query = 1'b1;
        step();
        query = 1'b0;
    endtask

    task automatic do_eoi();
        eoi = 1'b1;
        step();
        eoi = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; irq = '0; nmi = 1'b0; intd = 1'b0;
        mask_we = 1'b0; mask_wdata = '0; query = 1'b0; eoi = 1'b0;
        step(); step();
        chk("rst_take", 32'(take), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mask", 32'(mask), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_ina", 32'(ina), 32'd0);
        rst_n = 1'b1;
        step();

        // masked channel is held pending but not granted
        irq = 8'h08; step(); irq = '0;
        chk("t1_pend", 32'(pending), 32'h08);
        do_query();
        chk("t1_masked_take", 32'(take), 32'd0);
        mask_we = 1'b1; mask_wdata = 8'h08; step(); mask_we = 1'b0;
        chk("t1_mask", 32'(mask), 32'h08);
        do_query();
        chk("t1_take", 32'(take), 32'd1);
        chk("t1_id", 32'(take_id), 32'd3);
        chk("t1_ina", 32'(ina), 32'd1);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_pend_clr", 32'(pending), 32'd0);
        step();
        chk("t1_take_pulse", 32'(take), 32'd0);
        chk("t1_id_hold", 32'(take_id), 32'd3);
        do_eoi();
        chk("t1_idle", 32'(busy), 32'd0);

        // priority: lowest index first; eoi+query in one cycle regrants
        mask_we = 1'b1; mask_wdata = 8'hFF; step(); mask_we = 1'b0;
        irq = 8'h24; step(); irq = '0;
        do_query();
        chk("t2_id2", 32'(take_id), 32'd2);
        chk("t2_pend", 32'(pending), 32'h20);
        eoi = 1'b1; query = 1'b1; step(); eoi = 1'b0; query = 1'b0;
        chk("t2_take5", 32'(take), 32'd1);
        chk("t2_id5", 32'(take_id), 32'd5);
        chk("t2_pend0", 32'(pending), 32'd0);
        do_eoi();

        // NMI preempts INT id 4, then unwinds one level per eoi
        irq = 8'h10; step(); irq = '0;
        do_query();
        chk("t3_id4", 32'(take_id), 32'd4);
        nmi = 1'b1; step(); nmi = 1'b0;
        do_query();
        chk("t3_take", 32'(take), 32'd1);
        chk("t3_nmi", 32'(take_nmi), 32'd1);
        chk("t3_ina", 32'(ina), 32'd0);
        chk("t3_id0", 32'(take_id), 32'd0);
        do_eoi();
        chk("t3_back_int", 32'(busy), 32'd1);
        do_query();
        chk("t3_no_nest_int", 32'(take), 32'd0);
        do_eoi();
        chk("t3_idle", 32'(busy), 32'd0);

        // intd blocks INT but not NMI
        intd = 1'b1;
        irq = 8'h02; step(); irq = '0;
        do_query();
        chk("t4_intd_take", 32'(take), 32'd0);
        nmi = 1'b1; step(); nmi = 1'b0;
        do_query();
        chk("t4_nmi_take", 32'(take), 32'd1);
        chk("t4_nmi", 32'(take_nmi), 32'd1);
        do_eoi();
        chk("t4_idle", 32'(busy), 32'd0);
        intd = 1'b0;
        do_query();
        chk("t4_take1", 32'(take), 32'd1);
        chk("t4_id1", 32'(take_id), 32'd1);
        chk("t4_nmi_clr", 32'(take_nmi), 32'd0);
        do_eoi();

        // simultaneous nmi and irq edges: NMI first, INT stays pending
        nmi = 1'b1; irq = 8'h80; step(); nmi = 1'b0; irq = '0;
        do_query();
        chk("t5_nmi", 32'(take_nmi), 32'd1);
        chk("t5_pend", 32'(pending), 32'h80);
        do_eoi();
        do_query();
        chk("t5_id7", 32'(take_id), 32'd7);
        do_eoi();

        // level channel 0 regrants while the line is high
        irq = 8'h01; step();
        do_query();
        chk("t6_id0", 32'(take_id), 32'd0);
        chk("t6_ina", 32'(ina), 32'd1);
        do_eoi();
        do_query();
        chk("t6_regrant", 32'(take), 32'd1);
        chk("t6_regrant_id", 32'(take_id), 32'd0);
        do_eoi();
        irq = '0; step();
        do_query();
        chk("t6_dropped", 32'(take), 32'd0);

        // async reset while nested in NMI_SVC
        irq = 8'h40; step(); irq = '0;
        do_query();
        nmi = 1'b1; step(); nmi = 1'b0;
        do_query();
        chk("t7_nmi", 32'(take_nmi), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t7_rst_take", 32'(take), 32'd0);
        chk("t7_rst_nmi", 32'(take_nmi), 32'd0);
        chk("t7_rst_busy", 32'(busy), 32'd0);
        chk("t7_rst_mask", 32'(mask), 32'd0);
        chk("t7_rst_id", 32'(take_id), 32'd0);
        step(); step();
        rst_n = 1'b1;
        step();
        do_query();
        chk("t7_post_take", 32'(take), 32'd0);
        chk("t7_post_busy", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
